// File: rtl/alarm_ringer_pkg.sv
// Shared definitions for the alarm ringing session: state encoding,
// default timing constants and small width helpers.
package alarm_ringer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ring_state_e;

  localparam int unsigned DEF_RING_SECS   = 60;
  localparam int unsigned DEF_SNOOZE_SECS = 300;
  localparam int unsigned DEF_MAX_SNOOZE  = 3;

  // Board clock and the buzzer tone it is divided down to.
  localparam int unsigned CP_FREQ_HZ    = 100_000_000;
  localparam int unsigned TONE_FREQ_HZ  = 1_000;
  localparam int unsigned DEF_BUZZ_HALF = CP_FREQ_HZ / (2 * TONE_FREQ_HZ);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ringer_tone.sv
// Buzzer square-wave generator: a divider counting 0..BUZZ_HALF-1 that
// toggles the tone at each wrap. Dropping en_i clears divider and tone so
// every ringing burst starts from a known phase. The next-state tone is
// exported so the parent can register the gated buzzer on the same edge.
module buzzer_tone_gen
  import alarm_ringer_pkg::*;
#(
  parameter int unsigned BUZZ_HALF = DEF_BUZZ_HALF
) (
  input  logic CP,
  input  logic _CR,
  input  logic en_i,
  output logic tone_d_o
);

  localparam int unsigned DIV_W = cnt_width(BUZZ_HALF);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d;

  // Divider advance and tone toggle at the half-period boundary.
  always_comb begin
    div_d  = div_q;
    tone_d = tone_q;
    if (!en_i) begin
      div_d  = '0;
      tone_d = 1'b0;
    end else if (div_q == DIV_W'(BUZZ_HALF - 1)) begin
      div_d  = '0;
      tone_d = ~tone_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider and tone registers.
  always_ff @(posedge CP) begin
    if (!_CR) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tone_q <= tone_d;
    end
  end

  assign tone_d_o = tone_d;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringing session controller: starts on a rising match edge while
// armed, drives an LED chaser and a beeping buzzer, supports a limited
// number of snoozes and stops by itself after a fixed ringing time.
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int unsigned LED_W       = 16,
  parameter int unsigned RING_SECS   = DEF_RING_SECS,
  parameter int unsigned SNOOZE_SECS = DEF_SNOOZE_SECS,
  parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE,
  parameter int unsigned BUZZ_HALF   = DEF_BUZZ_HALF
) (
  input  logic             CP,
  input  logic             _CR,
  input  logic             tick_1hz,
  input  logic             start_light_alarm,
  input  logic             active_alarm,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic [LED_W-1:0] led,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [1:0]       snooze_cnt
);

  localparam int unsigned SEC_W = cnt_width(max_u(RING_SECS, SNOOZE_SECS));
  localparam logic [LED_W-1:0] LED_FIRST = LED_W'(1);

  ring_state_e      state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             buzz_q, buzz_d;
  logic             ring_q, snz_q;
  logic             start_prev_q;
  logic             edge_ok_q;
  logic             trig;
  logic             ring_next;
  logic             tone_en;
  logic             tone_next;

  // A level already high when reset releases is not a fresh match, so the
  // edge detector is only trusted once it has captured a real sample.
  assign trig = start_light_alarm & ~start_prev_q & active_alarm & edge_ok_q;

  // Next-state, timers and LED pattern; stop/disarm outrank everything else.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    if (stop_btn || !active_alarm) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      led_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d = ST_RING;
            sec_d   = '0;
            cnt_d   = '0;
            led_d   = LED_FIRST;
          end
        end
        ST_RING: begin
          if (snooze_btn) begin
            sec_d = '0;
            led_d = '0;
            if (cnt_q < 2'(MAX_SNOOZE)) begin
              state_d = ST_SNOOZE;
              cnt_d   = cnt_q + 2'd1;
            end else begin
              // Out of snoozes: the request ends the session like stop.
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else if (tick_1hz) begin
            if (sec_q == SEC_W'(RING_SECS - 1)) begin
              // Timeout keeps snooze_cnt visible until the next trigger.
              state_d = ST_IDLE;
              sec_d   = '0;
              led_d   = '0;
            end else begin
              sec_d = sec_q + SEC_W'(1);
              led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            end
          end
        end
        ST_SNOOZE: begin
          if (tick_1hz) begin
            if (sec_q == SEC_W'(SNOOZE_SECS - 1)) begin
              state_d = ST_RING;
              sec_d   = '0;
              led_d   = LED_FIRST;
            end else begin
              sec_d = sec_q + SEC_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          sec_d   = '0;
          led_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The tone only runs while staying in RING; entering RING restarts it.
  assign ring_next = (state_d == ST_RING);
  assign tone_en   = (state_q == ST_RING) & ring_next;
  assign buzz_d    = ring_next & tone_next & ~sec_d[0];

  buzzer_tone_gen #(
    .BUZZ_HALF(BUZZ_HALF)
  ) u_tone (
    .CP      (CP),
    ._CR     (_CR),
    .en_i    (tone_en),
    .tone_d_o(tone_next)
  );

  // State, timers and registered outputs, all updated on the same edge.
  always_ff @(posedge CP) begin
    if (!_CR) begin
      state_q      <= ST_IDLE;
      sec_q        <= '0;
      led_q        <= '0;
      cnt_q        <= '0;
      buzz_q       <= 1'b0;
      ring_q       <= 1'b0;
      snz_q        <= 1'b0;
      start_prev_q <= 1'b0;
      edge_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      led_q        <= led_d;
      cnt_q        <= cnt_d;
      buzz_q       <= buzz_d;
      ring_q       <= ring_next;
      snz_q        <= (state_d == ST_SNOOZE);
      start_prev_q <= start_light_alarm;
      edge_ok_q    <= 1'b1;
    end
  end

  assign led        = led_q;
  assign buzzer     = buzz_q;
  assign ringing    = ring_q;
  assign snoozing   = snz_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed session scenarios followed by a random
// phase, every cycle compared against a session-level behavioural model.
module tb_alarm_ringer;

  localparam int LED_W       = 4;
  localparam int RING_SECS   = 5;
  localparam int SNOOZE_SECS = 3;
  localparam int MAX_SNOOZE  = 2;
  localparam int BUZZ_HALF   = 4;
  localparam int TICK_P      = 20;

  logic             CP = 1'b0;
  logic             _CR;
  logic             tick_1hz;
  logic             start_light_alarm;
  logic             active_alarm;
  logic             snooze_btn;
  logic             stop_btn;
  logic [LED_W-1:0] led;
  logic             buzzer;
  logic             ringing;
  logic             snoozing;
  logic [1:0]       snooze_cnt;

  always #5 CP = ~CP;

  alarm_ringer #(
    .LED_W      (LED_W),
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS),
    .MAX_SNOOZE (MAX_SNOOZE),
    .BUZZ_HALF  (BUZZ_HALF)
  ) dut (
    .CP               (CP),
    ._CR              (_CR),
    .tick_1hz         (tick_1hz),
    .start_light_alarm(start_light_alarm),
    .active_alarm     (active_alarm),
    .snooze_btn       (snooze_btn),
    .stop_btn         (stop_btn),
    .led              (led),
    .buzzer           (buzzer),
    .ringing          (ringing),
    .snoozing         (snoozing),
    .snooze_cnt       (snooze_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit last_tick;

  // Session model: which phase we are in, seconds elapsed in that phase,
  // snoozes used, chaser position and cycles spent ringing since entry.
  bit m_ring, m_snz, m_prev;
  int m_sec, m_cnt, m_pos, m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit trig;
    if (!_CR) begin
      m_ring = 0; m_snz = 0; m_sec = 0; m_cnt = 0; m_pos = 0; m_age = 0;
      m_prev = 1;  // a level present at reset release is not an edge
    end else begin
      trig = start_light_alarm && !m_prev && active_alarm;
      if (stop_btn || !active_alarm) begin
        m_ring = 0; m_snz = 0; m_sec = 0; m_cnt = 0;
      end else if (m_ring) begin
        if (snooze_btn) begin
          m_ring = 0; m_sec = 0;
          if (m_cnt < MAX_SNOOZE) begin m_snz = 1; m_cnt++; end
          else m_cnt = 0;
        end else begin
          m_age++;
          if (tick_1hz) begin
            if (m_sec == RING_SECS - 1) begin m_ring = 0; m_sec = 0; end
            else begin m_sec++; m_pos = (m_pos + 1) % LED_W; end
          end
        end
      end else if (m_snz) begin
        if (tick_1hz) begin
          if (m_sec == SNOOZE_SECS - 1) begin
            m_snz = 0; m_ring = 1; m_sec = 0; m_pos = 0; m_age = 0;
          end else m_sec++;
        end
      end else if (trig) begin
        m_ring = 1; m_sec = 0; m_cnt = 0; m_pos = 0; m_age = 0;
      end
      m_prev = start_light_alarm;
    end
  endtask

  task automatic cyc_step(input bit snz, input bit stp);
    logic [LED_W-1:0] exp_led;
    bit exp_buzz;
    tick_1hz   = ((cyc % TICK_P) == TICK_P - 1);
    last_tick  = tick_1hz;
    snooze_btn = snz;
    stop_btn   = stp;
    model_edge();
    @(posedge CP);
    #1;
    cyc++;
    exp_led  = m_ring ? LED_W'(1 << m_pos) : '0;
    exp_buzz = m_ring && (((m_age / BUZZ_HALF) % 2) == 1) && ((m_sec % 2) == 0);
    chk("model_ringing",  32'(ringing),    32'(m_ring));
    chk("model_snoozing", 32'(snoozing),   32'(m_snz));
    chk("model_led",      32'(led),        32'(exp_led));
    chk("model_buzzer",   32'(buzzer),     32'(exp_buzz));
    chk("model_cnt",      32'(snooze_cnt), 32'(m_cnt));
    snooze_btn = 0;
    stop_btn   = 0;
    tick_1hz   = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0);
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < TICK_P; i++) begin
      cyc_step(0, 0);
      if (last_tick) break;
    end
  endtask

  task automatic run_snooze(input string tag);
    int ticks = 0;
    for (int i = 0; i < 10 * TICK_P && snoozing; i++) begin
      cyc_step(0, 0);
      if (last_tick) ticks++;
    end
    chk({tag, "_ticks"}, 32'(ticks), 32'(SNOOZE_SECS));
    chk({tag, "_resume"}, 32'(ringing), 32'd1);
    chk({tag, "_led"}, 32'(led), 32'b0001);
  endtask

  initial begin
    int hi;
    _CR = 0; tick_1hz = 0; start_light_alarm = 0; active_alarm = 0;
    snooze_btn = 0; stop_btn = 0;

    run(3);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_ringing", 32'(ringing), 32'd0);
    $display("[TB] reset applied, outputs idle");
    _CR = 1; active_alarm = 1;
    run(5);

    // Arm and trigger.
    start_light_alarm = 1;
    cyc_step(0, 0);
    chk("trig_ringing", 32'(ringing), 32'd1);
    chk("trig_led", 32'(led), 32'b0001);
    run(BUZZ_HALF);
    chk("buzz_sec0_high", 32'(buzzer), 32'd1);
    run_to_tick();
    chk("first_tick_led", 32'(led), 32'b0010);
    hi = 0;
    for (int i = 0; i < TICK_P - 1; i++) begin cyc_step(0, 0); hi += int'(buzzer); end
    chk("sec1_silent", 32'(hi), 32'd0);
    $display("[TB] trigger: ringing, chaser and beep checked");

    // No response: timeout after RING_SECS ticks.
    for (int i = 0; i < RING_SECS - 1; i++) run_to_tick();
    chk("timeout_ringing", 32'(ringing), 32'd0);
    chk("timeout_led", 32'(led), 32'd0);
    chk("timeout_cnt", 32'(snooze_cnt), 32'd0);
    $display("[TB] no response: auto timeout");
    start_light_alarm = 0;
    run(2);

    // Snooze twice, third request ends the session.
    start_light_alarm = 1;
    cyc_step(0, 0);
    run(3);
    cyc_step(1, 0);
    chk("snz1_snoozing", 32'(snoozing), 32'd1);
    chk("snz1_cnt", 32'(snooze_cnt), 32'd1);
    chk("snz1_led", 32'(led), 32'd0);
    run_snooze("snz1");
    run(7);
    cyc_step(1, 0);
    chk("snz2_cnt", 32'(snooze_cnt), 32'd2);
    run_snooze("snz2");
    cyc_step(1, 0);
    chk("snz3_ringing", 32'(ringing), 32'd0);
    chk("snz3_snoozing", 32'(snoozing), 32'd0);
    $display("[TB] snooze limit: two snoozes then idle");
    start_light_alarm = 0;
    run(2);

    // Simultaneous snooze and stop.
    start_light_alarm = 1;
    cyc_step(0, 0);
    run(2);
    cyc_step(1, 0);
    run_snooze("snz_pre_stop");
    chk("pre_stop_cnt", 32'(snooze_cnt), 32'd1);
    cyc_step(1, 1);
    chk("both_ringing", 32'(ringing), 32'd0);
    chk("both_snoozing", 32'(snoozing), 32'd0);
    chk("both_cnt", 32'(snooze_cnt), 32'd0);
    $display("[TB] snooze with stop: stop wins");
    start_light_alarm = 0;
    run(2);

    // Disarm during SNOOZE.
    start_light_alarm = 1;
    cyc_step(0, 0);
    cyc_step(1, 0);
    run(3);
    active_alarm = 0;
    cyc_step(0, 0);
    chk("disarm_snoozing", 32'(snoozing), 32'd0);
    chk("disarm_cnt", 32'(snooze_cnt), 32'd0);
    $display("[TB] disarm during snooze: idle");

    // Held level with alarm disarmed at the edge.
    start_light_alarm = 0;
    cyc_step(0, 0);
    start_light_alarm = 1;
    run(3);
    active_alarm = 1;
    run(10);
    chk("held_no_ring", 32'(ringing), 32'd0);
    $display("[TB] held level while disarmed: no ringing");

    // Reset mid-RING with level held.
    start_light_alarm = 0;
    cyc_step(0, 0);
    start_light_alarm = 1;
    cyc_step(0, 0);
    run(5);
    chk("pre_reset_ringing", 32'(ringing), 32'd1);
    _CR = 0;
    cyc_step(0, 0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_ringing", 32'(ringing), 32'd0);
    _CR = 1;
    run(10);
    chk("rst_no_retrigger", 32'(ringing), 32'd0);
    $display("[TB] reset mid-ring: idle, held level ignored");

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) start_light_alarm = ~start_light_alarm;
      if (active_alarm) begin
        if ($urandom_range(0, 999) < 3) active_alarm = 0;
      end else if ($urandom_range(0, 99) < 20) active_alarm = 1;
      _CR = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
      cyc_step($urandom_range(0, 99) < 1, $urandom_range(0, 999) < 3);
    end
    _CR = 1;
    $display("[TB] random phase: %0d cycles compared", 4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
